// File: rtl/draw_sprite_hit.sv
// Sprite overlay stage: draws a rotated, colour-keyed ROM sprite at a frame-latched position
// and turns mouse clicks on it into a flash/cooldown sequence with a saturating score.
module draw_sprite_hit #(
  parameter int unsigned WIDTH           = 53,
  parameter int unsigned HEIGHT          = 54,
  parameter int unsigned ADDR_W          = 12,
  parameter logic [11:0] TRANSPARENT     = 12'h000,
  parameter logic [11:0] FLASH_COLOR     = 12'hFFF,
  parameter int unsigned FLASH_CYCLES    = 110000,
  parameter int unsigned COOLDOWN_CYCLES = 1000,
  parameter int unsigned SCORE_W         = 4
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic [11:0]        hcount_in,
  input  logic [11:0]        vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [11:0]        rgb_in,
  input  logic [11:0]        x_pos,
  input  logic [11:0]        y_pos,
  input  logic [1:0]         rotation,
  input  logic               sprite_en,
  input  logic [11:0]        xpos,
  input  logic [11:0]        ypos,
  input  logic               mouse_left,
  input  logic               score_clear,
  output logic [ADDR_W-1:0]  pixel_addr,
  input  logic [11:0]        rgb_pixel,
  output logic [11:0]        hcount_out,
  output logic [11:0]        vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [11:0]        rgb_out,
  output logic               hit,
  output logic               busy,
  output logic [SCORE_W-1:0] score
);

  localparam int unsigned MAX_CYC = (FLASH_CYCLES > COOLDOWN_CYCLES) ? FLASH_CYCLES
                                                                     : COOLDOWN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;

  typedef enum logic [1:0] {StIdle, StFlash, StCooldown} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mouse_left_q;
  logic               vblnk_q;
  logic [11:0]        xl, yl;
  logic [1:0]         rl;
  logic               enl;

  logic [12:0]        bw, bh, xl13, yl13;
  logic               in_box, mouse_in, click;
  logic [11:0]        lx, ly, row, col;
  logic [23:0]        addr_full;

  logic [11:0]        hcount_d1, vcount_d1, rgb_d1;
  logic               hsync_d1, vsync_d1, hblnk_d1, vblnk_d1, in_box_d1;

  // Position, rotation and enable only change at the start of vertical blanking.
  always_ff @(posedge pclk) begin
    if (reset) begin
      vblnk_q <= 1'b0;
      xl      <= '0;
      yl      <= '0;
      rl      <= '0;
      enl     <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      if (vblnk_in && !vblnk_q) begin
        xl  <= x_pos;
        yl  <= y_pos;
        rl  <= rotation;
        enl <= sprite_en;
      end
    end
  end

  always_comb begin
    bw   = rl[0] ? 13'(HEIGHT) : 13'(WIDTH);
    bh   = rl[0] ? 13'(WIDTH) : 13'(HEIGHT);
    xl13 = {1'b0, xl};
    yl13 = {1'b0, yl};
    // 13-bit compares keep xl+bw from wrapping near the 12-bit limit.
    in_box   = enl && ({1'b0, hcount_in} >= xl13) && ({1'b0, hcount_in} < xl13 + bw)
                   && ({1'b0, vcount_in} >= yl13) && ({1'b0, vcount_in} < yl13 + bh);
    mouse_in = enl && ({1'b0, xpos} >= xl13) && ({1'b0, xpos} < xl13 + bw)
                   && ({1'b0, ypos} >= yl13) && ({1'b0, ypos} < yl13 + bh);
    click    = mouse_left && !mouse_left_q;
    lx       = hcount_in - xl;
    ly       = vcount_in - yl;
    case (rl)
      2'b00:   begin row = ly;                   col = lx;                  end
      2'b01:   begin row = 12'(HEIGHT - 1) - lx; col = ly;                  end
      2'b10:   begin row = 12'(HEIGHT - 1) - ly; col = 12'(WIDTH - 1) - lx; end
      default: begin row = lx;                   col = 12'(WIDTH - 1) - ly; end
    endcase
    addr_full  = 24'(row) * 24'(WIDTH) + 24'(col);
    pixel_addr = in_box ? addr_full[ADDR_W-1:0] : '0;
  end

  // Stage 1 aligns timing with the ROM read; stage 2 picks the final pixel.
  always_ff @(posedge pclk) begin
    if (reset) begin
      hcount_d1  <= '0;
      vcount_d1  <= '0;
      hsync_d1   <= 1'b0;
      vsync_d1   <= 1'b0;
      hblnk_d1   <= 1'b0;
      vblnk_d1   <= 1'b0;
      rgb_d1     <= '0;
      in_box_d1  <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_d1  <= hcount_in;
      vcount_d1  <= vcount_in;
      hsync_d1   <= hsync_in;
      vsync_d1   <= vsync_in;
      hblnk_d1   <= hblnk_in;
      vblnk_d1   <= vblnk_in;
      rgb_d1     <= rgb_in;
      in_box_d1  <= in_box;
      hcount_out <= hcount_d1;
      vcount_out <= vcount_d1;
      hsync_out  <= hsync_d1;
      vsync_out  <= vsync_d1;
      hblnk_out  <= hblnk_d1;
      vblnk_out  <= vblnk_d1;
      if (hblnk_d1 || vblnk_d1) begin
        rgb_out <= '0;
      end else if (in_box_d1 && (rgb_pixel != TRANSPARENT)) begin
        rgb_out <= (state == StFlash) ? FLASH_COLOR : rgb_pixel;
      end else begin
        rgb_out <= rgb_d1;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state        <= StIdle;
      cnt          <= '0;
      hit          <= 1'b0;
      busy         <= 1'b0;
      score        <= '0;
      mouse_left_q <= 1'b0;
    end else begin
      mouse_left_q <= mouse_left;
      hit          <= 1'b0;
      case (state)
        StIdle: begin
          if (click && mouse_in) begin
            state <= StFlash;
            cnt   <= CNT_W'(FLASH_CYCLES - 1);
            hit   <= 1'b1;
            busy  <= 1'b1;
            if (score != '1) score <= score + 1'b1;
          end
        end
        StFlash: begin
          if (cnt == '0) begin
            state <= StCooldown;
            cnt   <= CNT_W'(COOLDOWN_CYCLES - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        StCooldown: begin
          if (cnt == '0) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
        end
      endcase
      if (score_clear) score <= '0;
    end
  end

endmodule

// File: tb/tb_draw_sprite_hit.sv
// Directed bench for draw_sprite_hit: latency, rotations, colour key, frame latch, hit FSM.
module tb_draw_sprite_hit;

  logic        pclk = 1'b0;
  logic        reset;
  logic [11:0] hcount_in, vcount_in, rgb_in, x_pos, y_pos, xpos, ypos, rgb_pixel;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in, sprite_en, mouse_left, score_clear;
  logic [1:0]  rotation;
  logic [11:0] pixel_addr, hcount_out, vcount_out, rgb_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out, hit, busy;
  logic [3:0]  score;
  logic [1:0]  rom_mode;

  int n_checks = 0;
  int n_fail   = 0;

  draw_sprite_hit #(
    .FLASH_CYCLES   (10),
    .COOLDOWN_CYCLES(5)
  ) dut (
    .pclk       (pclk),
    .reset      (reset),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .rotation   (rotation),
    .sprite_en  (sprite_en),
    .xpos       (xpos),
    .ypos       (ypos),
    .mouse_left (mouse_left),
    .score_clear(score_clear),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out),
    .hit        (hit),
    .busy       (busy),
    .score      (score)
  );

  always #5 pclk = ~pclk;

  // ROM model: one-cycle read, data = address, all-transparent, or solid green.
  always_ff @(posedge pclk) begin
    case (rom_mode)
      2'd0:    rgb_pixel <= pixel_addr;
      2'd1:    rgb_pixel <= 12'h000;
      default: rgb_pixel <= 12'h0F0;
    endcase
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic latch(input logic [11:0] x, input logic [11:0] y, input logic [1:0] r,
                       input logic en);
    x_pos = x; y_pos = y; rotation = r; sprite_en = en;
    vblnk_in = 1'b0; step();
    vblnk_in = 1'b1; step();
    vblnk_in = 1'b0; step();
  endtask

  task automatic pix(input logic [11:0] h, input logic [11:0] v);
    hcount_in = h; vcount_in = v; #1;
  endtask

  logic [39:0] exp_hist [0:39];
  int busy_n, flash_n, hit_n, waited;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; hcount_in = '0; vcount_in = '0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = '0; x_pos = '0; y_pos = '0; rotation = '0;
    sprite_en = 0; xpos = '0; ypos = '0; mouse_left = 0; score_clear = 0; rom_mode = 2'd0;
    rgb_in = 12'hABC; hcount_in = 12'd5;
    step(); step(); step();
    check_eq("reset_outputs", {hcount_out, vcount_out, rgb_out, hsync_out, vsync_out,
                               hblnk_out, vblnk_out, hit, busy, score}, '0);
    check_eq("reset_addr", pixel_addr, '0);
    reset = 1'b0;

    // Sprite disabled: pure 2-cycle delay line with blanking forcing black.
    for (int i = 0; i < 40; i++) begin
      hcount_in = 12'(i * 7); vcount_in = 12'(i);
      hsync_in = i[1]; vsync_in = i[3];
      hblnk_in = (i % 5 == 4); vblnk_in = (i % 11 == 10);
      rgb_in = 12'($urandom);
      exp_hist[i] = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in,
                     (hblnk_in || vblnk_in) ? 12'h000 : rgb_in};
      step();
      if (i >= 1)
        check_eq("latency", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out,
                             vblnk_out, rgb_out}, exp_hist[i-1]);
    end
    hblnk_in = 0; vblnk_in = 0; hsync_in = 0; vsync_in = 0;

    // Rotation 0
    latch(12'd100, 12'd50, 2'b00, 1'b1);
    rgb_in = 12'h555;
    pix(12'd100, 12'd50); check_eq("r0_addr_origin", pixel_addr, 12'd0);
    pix(12'd101, 12'd50); check_eq("r0_addr_1", pixel_addr, 12'd1);
    step(); step(); check_eq("r0_rgb_1", rgb_out, 12'd1);
    pix(12'd101, 12'd51); check_eq("r0_addr_row1", pixel_addr, 12'd54);
    pix(12'd99, 12'd50); check_eq("r0_outside_addr", pixel_addr, 12'd0);
    step(); step(); check_eq("r0_outside_rgb", rgb_out, 12'h555);
    pix(12'd101, 12'd50); hblnk_in = 1'b1;
    step(); step(); check_eq("blank_priority", rgb_out, 12'h000);
    hblnk_in = 1'b0;

    // Rotation 90 CW: box 54 wide, 53 tall
    latch(12'd100, 12'd50, 2'b01, 1'b1);
    pix(12'd100, 12'd50); check_eq("r1_addr_origin", pixel_addr, 12'd2809);
    pix(12'd153, 12'd102); check_eq("r1_addr_corner", pixel_addr, 12'd52);
    step(); step(); check_eq("r1_rgb_corner", rgb_out, 12'd52);
    pix(12'd154, 12'd60); check_eq("r1_right_edge_addr", pixel_addr, 12'd0);
    step(); step(); check_eq("r1_right_edge_rgb", rgb_out, 12'h555);
    pix(12'd100, 12'd103);
    step(); step(); check_eq("r1_bottom_edge_rgb", rgb_out, 12'h555);

    latch(12'd100, 12'd50, 2'b10, 1'b1);
    pix(12'd100, 12'd50); check_eq("r2_addr_origin", pixel_addr, 12'd2861);
    latch(12'd100, 12'd50, 2'b11, 1'b1);
    pix(12'd100, 12'd50); check_eq("r3_addr_origin", pixel_addr, 12'd52);
    pix(12'd101, 12'd51); check_eq("r3_addr_1_1", pixel_addr, 12'd104);

    // Colour key
    latch(12'd100, 12'd50, 2'b00, 1'b1);
    pix(12'd110, 12'd60);
    rom_mode = 2'd1; step(); step(); step(); check_eq("transparent", rgb_out, 12'h555);
    rom_mode = 2'd2; step(); step(); step(); check_eq("opaque_green", rgb_out, 12'h0F0);
    rom_mode = 2'd0;

    // Frame latch: move request mid-frame
    x_pos = 12'd300;
    pix(12'd101, 12'd50); check_eq("latch_hold_old", pixel_addr, 12'd1);
    pix(12'd301, 12'd50); step(); step(); check_eq("latch_hold_new_rgb", rgb_out, 12'h555);
    latch(12'd300, 12'd50, 2'b00, 1'b1);
    pix(12'd301, 12'd50); check_eq("latch_after_vblnk", pixel_addr, 12'd1);

    // Disabled sprite is not clickable
    latch(12'd100, 12'd50, 2'b00, 1'b0);
    xpos = 12'd110; ypos = 12'd60;
    mouse_left = 1'b1; step();
    check_eq("disabled_no_hit", {hit, busy}, 2'b00);
    mouse_left = 1'b0; step();

    // First hit: 10 flash cycles, 15 busy cycles
    latch(12'd100, 12'd50, 2'b00, 1'b1);
    pix(12'd101, 12'd50);
    mouse_left = 1'b1; step();
    check_eq("hit_pulse", hit, 1'b1);
    check_eq("score_1", score, 4'd1);
    busy_n = 0; flash_n = 0; hit_n = 0;
    for (int k = 0; k < 30; k++) begin
      busy_n += int'(busy); hit_n += int'(hit); flash_n += int'(rgb_out == 12'hFFF);
      if (k == 0) mouse_left = 1'b0;
      step();
    end
    check_eq("busy_cycles", busy_n, 15);
    check_eq("flash_cycles", flash_n, 10);
    check_eq("single_pulse", hit_n, 1);
    check_eq("rgb_after_flash", rgb_out, 12'd1);

    // Second hit, re-click while busy and hold through the return to idle
    mouse_left = 1'b1; step();
    hit_n = 0;
    for (int k = 0; k < 30; k++) begin
      hit_n += int'(hit);
      if (k == 0) mouse_left = 1'b0;
      if (k == 2) mouse_left = 1'b1;
      step();
    end
    check_eq("busy_and_held_hits", hit_n, 1);
    check_eq("score_2", score, 4'd2);
    check_eq("idle_after_hold", busy, 1'b0);
    mouse_left = 1'b0; step();

    // Saturation
    for (int n = 0; n < 20; n++) begin
      mouse_left = 1'b1; step();
      mouse_left = 1'b0;
      waited = 0;
      while (busy && waited < 40) begin step(); waited++; end
      if (waited >= 40) check_eq("busy_timeout", busy, 1'b0);
    end
    check_eq("score_saturated", score, 4'd15);

    // Clear coinciding with a hit
    score_clear = 1'b1; mouse_left = 1'b1; step();
    check_eq("clear_hit_pulse", {hit, busy}, 2'b11);
    check_eq("clear_wins", score, 4'd0);
    score_clear = 1'b0; mouse_left = 1'b0; step();
    check_eq("clear_pulse_ends", hit, 1'b0);

    // Reset during FLASH
    step();
    reset = 1'b1; step();
    check_eq("reset_mid_flash", {hit, busy, score, rgb_out}, '0);
    reset = 1'b0;
    latch(12'd100, 12'd50, 2'b00, 1'b1);
    mouse_left = 1'b1; step();
    check_eq("idle_after_reset", {hit, score}, {1'b1, 4'd1});
    mouse_left = 1'b0; step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_sprite_hit.md
Name: draw_sprite_hit

Overview:
- Parametrised sprite overlay for the VGA timing chain. Draws a WIDTHxHEIGHT ROM sprite at a frame-latched position, in 4 rotations, with colour-key transparency.
- Detects mouse clicks on the sprite, runs a flash/cooldown state machine and keeps a saturating score.
- Sits between the background/previous draw stage and the next draw stage. All timing outputs are delay-matched to rgb_out.

Parameters:
- WIDTH, 53, sprite width in pixels (unrotated).
- HEIGHT, 54, sprite height in pixels (unrotated).
- ADDR_W, 12, pixel_addr width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT.
- TRANSPARENT, 12'h000, ROM colour treated as transparent.
- FLASH_COLOR, 12'hFFF, colour of opaque sprite pixels during FLASH.
- FLASH_CYCLES, 110000, FLASH duration in pclk cycles (>=1).
- COOLDOWN_CYCLES, 1000, duration in pclk cycles during which clicks are ignored (>=1).
- SCORE_W, 4, score width.

Ports:
- pclk in 1: pixel clock.
- reset in 1: reset, synchronous, active-high; clock pclk.
- hcount_in, vcount_in in 12: pixel counters.
- hsync_in, vsync_in, hblnk_in, vblnk_in in 1: timing signals.
- rgb_in in 12: upstream pixel.
- x_pos, y_pos in 12: requested sprite top-left.
- rotation in 2: 00 = 0°, 01 = 90° CW, 10 = 180°, 11 = 270° CW.
- sprite_en in 1: 0 = sprite invisible and unclickable.
- xpos, ypos in 12: mouse position.
- mouse_left in 1: mouse button level.
- score_clear in 1: synchronous score clear.
- pixel_addr out ADDR_W: sprite ROM address, combinational from inputs.
- rgb_pixel in 12: ROM data, valid 1 cycle after pixel_addr.
- hcount_out, vcount_out out 12; hsync_out, vsync_out, hblnk_out, vblnk_out out 1; rgb_out out 12: delayed timing and pixel.
- hit out 1: one-cycle pulse on an accepted hit.
- busy out 1: high in FLASH or COOLDOWN.
- score out SCORE_W: hit count.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, latched position/rotation/enable = 0, counters 0, mouse edge register 0.
- Frame latch: on a vblnk_in 0->1 transition, x_pos, y_pos, rotation and sprite_en are captured into xl, yl, rl, enl. All drawing and hit tests use only the latched values.
- Box size: bw = WIDTH, bh = HEIGHT for rl 00/10; bw = HEIGHT, bh = WIDTH for rl 01/11.
- in_box = enl & hcount_in in [xl, xl+bw) & vcount_in in [yl, yl+bh). Compare at 13 bits so xl+bw never wraps.
- Local coordinates: lx = hcount_in - xl, ly = vcount_in - yl.
- ROM mapping, given as (row, col):
  - 00: (ly, lx)
  - 01: (HEIGHT-1-lx, ly)
  - 10: (HEIGHT-1-ly, WIDTH-1-lx)
  - 11: (lx, WIDTH-1-ly)
- pixel_addr = row*WIDTH + col. Outside the box pixel_addr = 0 (don't-care value, but fixed).
- Pipeline: fixed latency of 2 pclk on every output. Stage 1 registers timing, rgb_in and in_box. Stage 2 registers the final pixel.
- Stage-2 pixel selection, in priority order:
  1. Delayed hblnk or vblnk high -> 0.
  2. in_box and rgb_pixel != TRANSPARENT -> FLASH_COLOR if state is FLASH, else rgb_pixel.
  3. Otherwise -> delayed rgb_in.
- Click edge: click = mouse_left & ~mouse_left_q, so a held button counts once.
- Mouse hit test: enl & xpos in [xl, xl+bw) & ypos in [yl, yl+bh). Box only; transparency is ignored.
- FSM transitions:
  - IDLE: click & hit test -> FLASH; cnt <= FLASH_CYCLES-1; hit pulses for 1 cycle; score increments, saturating at 2^SCORE_W-1.
  - FLASH: cnt decrements each cycle; at cnt==0 -> COOLDOWN with cnt <= COOLDOWN_CYCLES-1. Clicks are ignored.
  - COOLDOWN: cnt decrements; at cnt==0 -> IDLE. Clicks are ignored. A click landing on the exact cycle of the COOLDOWN->IDLE transition is ignored.
- The FSM advances every cycle, independent of blanking.
- Counter width: clog2(max(FLASH_CYCLES, COOLDOWN_CYCLES)) + 1.
- score_clear: score <= 0 next cycle. If it coincides with an accepted hit, clear wins (score = 0); hit still pulses and the FSM still enters FLASH.
- A sprite_en drop mid-FLASH takes effect at the next frame latch. The FSM completes normally.
- Reset mid-operation: immediate return to IDLE, score 0, no hit pulse.

Test Plan:
- Latency: free-running 640x480 timing, sprite_en=0 -> rgb_out == rgb_in and all timing outputs delayed by exactly 2 cycles, with rgb_out=0 whenever the delayed blank is high.
- Draw/rotation: xl=100, yl=50, ROM data = address; pixel (100,50) -> addr 0 for rl=00; rl=01 pixel (100,50) -> addr 53*53=2809; rl=10 -> addr 2861; the 90° box spans hcount 100..153 and vcount 50..102.
- Transparency: ROM returns 12'h000 inside the box -> rgb_out = rgb_in; ROM 12'h0F0 -> rgb_out = 12'h0F0.
- Frame latch: change x_pos mid-frame from 100 to 300 -> the sprite stays at 100 until after the next vblnk rising edge.
- Hit FSM: FLASH_CYCLES=10, COOLDOWN_CYCLES=5, click at (110,60) -> hit pulse, score 1, opaque pixels = FFF for 10 cycles, busy for 15. A second click during busy -> score stays 1. Holding the button across the return to IDLE -> no new hit.
- Saturation/clear/reset: 20 hits -> score 15. score_clear plus a simultaneous hit -> score 0 and hit=1. Reset during FLASH -> state IDLE, score 0, busy 0.
